uart_rx_sample_gen: RTL and testbench

Parametrised successor to the receive-side baud/sample clock generator.
- Uses a fractional phase accumulator (NCO), so every supported baud is accurate to within ±1 system clock on average, with no integer-division truncation error.
- Oversampling ratio is a parameter.
- The block tracks the frame itself (start, data, parity, stop bits) and emits mid-bit strobes, bit index and frame end. The RX shifter therefore no longer has to feed Rx_Done back.
- Sits between the start-edge detector and the RX shift/vote logic.

---
 rtl/uart_pkg.sv | 58 +++++
 rtl/uart_rx_sample_gen_if.sv | 30 +++
 rtl/uart_nco_tick.sv | 41 ++++
 rtl/uart_rx_sample_gen.sv | 140 ++++++++++++++
 tb/tb_uart_rx_sample_gen.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and elaboration-time helpers for the UART receive
// sample generator: baud table, NCO step calculation, frame geometry.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Data_Bits encoding: 0..3 selects 5..8 data bits.
  typedef enum logic [1:0] {
    DB_5 = 2'd0,
    DB_6 = 2'd1,
    DB_7 = 2'd2,
    DB_8 = 2'd3
  } data_bits_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int NUM_BAUDS     = 8;
  localparam int BAUD_SEL_W    = 3;
  localparam int BIT_IDX_W     = 4;

  // Baud rate selected by Baud_Set.
  function automatic longint unsigned baud_of(input int sel);
    case (sel)
      0:       return 64'd9600;
      1:       return 64'd19200;
      2:       return 64'd38400;
      3:       return 64'd57600;
      4:       return 64'd115200;
      5:       return 64'd230400;
      6:       return 64'd460800;
      default: return 64'd921600;
    endcase
  endfunction

  // Phase increment so that the accumulator overflows os*baud times per
  // second; rounded to nearest to keep the long-run rate unbiased.
  function automatic longint unsigned calc_step(input longint unsigned baud,
                                                input longint unsigned os,
                                                input int unsigned     acc_w,
                                                input longint unsigned sys_hz);
    longint unsigned scale;
    scale = 64'd1 << acc_w;
    return (baud * os * scale + sys_hz / 64'd2) / sys_hz;
  endfunction

  // Bits per frame: start + data + optional parity + one or two stops.
  function automatic logic [BIT_IDX_W-1:0] frame_len(input logic [1:0] db,
                                                     input logic       par,
                                                     input logic       stop2);
    logic [BIT_IDX_W-1:0] len;
    len = 4'd1 + ({2'b00, db} + 4'(DATA_BITS_MIN)) + {3'b000, par} + 4'd1
        + {3'b000, stop2};
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_sample_gen_if.sv
// Control/status bundle between the start-edge detector, the sample
// generator and the RX shift/vote logic.
interface uart_rx_sample_gen_if;
  import uart_pkg::*;

  logic [BAUD_SEL_W-1:0] Baud_Set;
  logic [1:0]            Data_Bits;
  logic                  Parity_En;
  logic                  Stop2;
  logic                  Start;
  logic                  Abort;

  logic                  Sample_Tick;
  logic                  Bit_Mid;
  logic [BIT_IDX_W-1:0]  Bit_Idx;
  logic                  Frame_End;
  logic                  Busy;

  // Side that configures and starts frames, and consumes the strobes.
  modport master (
    output Baud_Set, Data_Bits, Parity_En, Stop2, Start, Abort,
    input  Sample_Tick, Bit_Mid, Bit_Idx, Frame_End, Busy
  );

  // The sample generator itself.
  modport slave (
    input  Baud_Set, Data_Bits, Parity_En, Stop2, Start, Abort,
    output Sample_Tick, Bit_Mid, Bit_Idx, Frame_End, Busy
  );
endinterface

// File: rtl/uart_nco_tick.sv
// Fractional phase accumulator: adds Step every enabled cycle and emits a
// registered one-cycle Tick on each overflow of the ACC_W-bit phase.
module uart_nco_tick #(
  parameter int ACC_W = 24
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Clr,
  input  logic             En,
  input  logic [ACC_W-1:0] Step,
  output logic             Tick
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q, tick_d;

  // Next phase; the bit above the accumulator is the carry-out.
  always_comb begin
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (Clr) begin
      acc_d = '0;
    end else if (En) begin
      {tick_d, acc_d} = {1'b0, acc_q} + {1'b0, Step};
    end
  end

  // Phase and carry registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign Tick = tick_q;

endmodule

// File: rtl/uart_rx_sample_gen.sv
// Receive-side sample clock generator: NCO-based oversampling ticks plus
// frame tracking (start, data, parity, stop) with mid-bit strobes.
module uart_rx_sample_gen
  import uart_pkg::*;
#(
  parameter int SYS_CLK_HZ = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24
) (
  input logic                 Clk,
  input logic                 Rst_n,
  uart_rx_sample_gen_if.slave sg_if
);

  localparam int             K_W    = $clog2(OVERSAMPLE);
  localparam logic [K_W-1:0] K_LAST = K_W'(OVERSAMPLE - 1);
  localparam logic [K_W-1:0] K_MID  = K_W'(OVERSAMPLE / 2 - 1);

  // One NCO increment per selectable baud, fixed at elaboration.
  logic [ACC_W-1:0] step_tab [NUM_BAUDS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BAUDS; gi++) begin : g_step
      localparam longint unsigned STEP_FULL =
        calc_step(baud_of(gi), longint'(OVERSAMPLE), ACC_W, longint'(SYS_CLK_HZ));
      assign step_tab[gi] = STEP_FULL[ACC_W-1:0];
    end
  endgenerate

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     step_q, step_d;
  logic [BIT_IDX_W-1:0] last_idx_q, last_idx_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic [K_W-1:0]       k_q, k_d;

  logic nco_clr;
  logic nco_en;
  logic nco_tick;
  logic start_ok;
  logic tick_s;
  logic bit_mid_s;
  logic frame_end_s;

  assign nco_en = (state_q == ST_RUN);

  uart_nco_tick #(
    .ACC_W (ACC_W)
  ) u_nco (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Clr   (nco_clr),
    .En    (nco_en),
    .Step  (step_q),
    .Tick  (nco_tick)
  );

  // Strobe decode; Abort masks anything still in flight this cycle.
  always_comb begin
    start_ok    = (state_q == ST_IDLE) && sg_if.Start && !sg_if.Abort;
    tick_s      = nco_tick && (state_q == ST_RUN) && !sg_if.Abort;
    bit_mid_s   = tick_s && (k_q == K_MID);
    frame_end_s = bit_mid_s && (idx_q == last_idx_q);
  end

  // Frame FSM and k / bit-index counters. The frame ends at the centre of
  // the last stop bit so the RX can re-arm for a back-to-back start.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    last_idx_d = last_idx_q;
    k_d        = k_q;
    idx_d      = idx_q;
    nco_clr    = 1'b0;

    if (sg_if.Abort) begin
      state_d = ST_IDLE;
      k_d     = '0;
      idx_d   = '0;
      nco_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_d    = ST_RUN;
            step_d     = step_tab[sg_if.Baud_Set];
            last_idx_d = frame_len(sg_if.Data_Bits, sg_if.Parity_En, sg_if.Stop2)
                         - 4'd1;
            k_d        = '0;
            idx_d      = '0;
            nco_clr    = 1'b1;
          end
        end
        ST_RUN: begin
          if (frame_end_s) begin
            state_d = ST_IDLE;
            k_d     = '0;
            idx_d   = '0;
            nco_clr = 1'b1;
          end else if (tick_s) begin
            if (k_q == K_LAST) begin
              k_d   = '0;
              idx_d = idx_q + 4'd1;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          nco_clr = 1'b1;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      last_idx_q <= '0;
      k_q        <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      last_idx_q <= last_idx_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
    end
  end

  assign sg_if.Sample_Tick = tick_s;
  assign sg_if.Bit_Mid     = bit_mid_s;
  assign sg_if.Frame_End   = frame_end_s;
  assign sg_if.Bit_Idx     = idx_q;
  assign sg_if.Busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_uart_rx_sample_gen.sv
// Self-checking bench for uart_rx_sample_gen: expected Bit_Idx sequences are
// queued when a frame is started and popped as Bit_Mid strobes arrive;
// timing is judged against the ideal baud period.
`timescale 1ns/1ps
module tb_uart_rx_sample_gen;

  localparam int SYS_HZ = 50_000_000;
  localparam int OS     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  int baud_tab [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

  int   exp_idx_q [$];
  int   mid_idx   [$];
  int   tick_cyc  [$];
  int   s_cyc, fe_cyc, fe_idx, fe_count, idx_after;
  logic busy_at_fe, busy_after;
  bit   timed_out;

  uart_rx_sample_gen_if sg_if ();

  uart_rx_sample_gen #(
    .SYS_CLK_HZ (SYS_HZ),
    .OVERSAMPLE (OS),
    .ACC_W      (24)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .sg_if (sg_if)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive a one-cycle Start and queue the Bit_Idx values the frame must show.
  task automatic start_frame(input int baud, input int db, input int par, input int st2);
    int n;
    sg_if.Baud_Set  = 3'(baud);
    sg_if.Data_Bits = 2'(db);
    sg_if.Parity_En = par[0];
    sg_if.Stop2     = st2[0];
    n = 1 + (db + 5) + par + 1 + st2;
    exp_idx_q.delete();
    mid_idx.delete();
    tick_cyc.delete();
    for (int i = 0; i < n; i++) exp_idx_q.push_back(i);
    sg_if.Start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    sg_if.Start = 1'b0;
  endtask

  // Record strobes on each falling edge until the cycle after Frame_End.
  task automatic collect(input int max_cyc, input bit disturb);
    bit seen_fe;
    bit done;
    int n;
    seen_fe = 0; done = 0; n = 0;
    timed_out = 0; fe_cyc = -1; fe_idx = -1; fe_count = 0;
    while (!done) begin
      if (sg_if.Sample_Tick) tick_cyc.push_back(cyc);
      if (sg_if.Bit_Mid) mid_idx.push_back(int'(sg_if.Bit_Idx));
      if (seen_fe) begin
        busy_after = sg_if.Busy;
        idx_after  = int'(sg_if.Bit_Idx);
        done = 1;
      end else begin
        if (sg_if.Frame_End) begin
          fe_cyc = cyc; fe_idx = int'(sg_if.Bit_Idx); fe_count++;
          busy_at_fe = sg_if.Busy; seen_fe = 1;
        end
        if (n >= max_cyc) begin timed_out = 1; done = 1; end
      end
      if (!done) begin
        if (disturb) begin
          sg_if.Start = !seen_fe && (n % 29 == 5);
          if (n % 13 == 0) sg_if.Baud_Set = sg_if.Baud_Set + 3'd1;
        end
        n++;
        @(negedge clk);
      end
    end
    sg_if.Start = 1'b0;
  endtask

  task automatic test_reset();
    int act;
    sg_if.Baud_Set = '0; sg_if.Data_Bits = '0; sg_if.Parity_En = 0;
    sg_if.Stop2 = 0; sg_if.Start = 0; sg_if.Abort = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sg_if.Busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", sg_if.Busy); end
    checks++; if (sg_if.Sample_Tick !== 1'b0) begin failures++; $display("FAIL rst_tick: got %b, required 0", sg_if.Sample_Tick); end
    checks++; if (sg_if.Bit_Mid !== 1'b0) begin failures++; $display("FAIL rst_mid: got %b, required 0", sg_if.Bit_Mid); end
    checks++; if (sg_if.Bit_Idx !== 4'd0) begin failures++; $display("FAIL rst_idx: got %0d, required 0", sg_if.Bit_Idx); end
    checks++; if (sg_if.Frame_End !== 1'b0) begin failures++; $display("FAIL rst_fe: got %b, required 0", sg_if.Frame_End); end
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (sg_if.Busy || sg_if.Sample_Tick || sg_if.Bit_Mid || sg_if.Frame_End) act++;
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL rst_idle: active cycles %0d, required 0", act); end
    $display("reset: outputs idle");
  endtask

  // One full frame; checks Bit_Idx sequence, tick count and frame timing.
  task automatic test_frame_timing(input string name, input int baud, input int db,
                                   input int par, input int st2,
                                   input int exp_last, input int exp_ticks);
    real p, ideal, delta, mean;
    int  obs, expv;
    start_frame(baud, db, par, st2);
    collect(60000, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL %s_timeout: no Frame_End, required one", name); end
    while (mid_idx.size() > 0) begin
      obs = mid_idx.pop_front();
      checks++;
      if (exp_idx_q.size() == 0) begin failures++; $display("FAIL %s_mid_extra: got Bit_Idx %0d, required none", name, obs); end
      else begin
        expv = exp_idx_q.pop_front();
        if (obs !== expv) begin failures++; $display("FAIL %s_mid_idx: got %0d, required %0d", name, obs, expv); end
      end
    end
    checks++; if (exp_idx_q.size() != 0) begin failures++; $display("FAIL %s_mid_missing: %0d Bit_Mid left, required 0", name, exp_idx_q.size()); end
    checks++; if (fe_idx !== exp_last) begin failures++; $display("FAIL %s_fe_idx: got %0d, required %0d", name, fe_idx, exp_last); end
    checks++; if (tick_cyc.size() !== exp_ticks) begin failures++; $display("FAIL %s_ticks: got %0d, required %0d", name, tick_cyc.size(), exp_ticks); end
    p     = real'(SYS_HZ) / (real'(baud_tab[baud]) * real'(OS));
    ideal = real'(exp_ticks) * p + 1.0;
    delta = real'(fe_cyc - s_cyc);
    checks++; if (delta < ideal - 2.0 || delta > ideal + 2.0) begin failures++; $display("FAIL %s_fe_time: got %0.1f clk, required %0.1f +-2", name, delta, ideal); end
    mean = 0.0;
    if (tick_cyc.size() > 1)
      mean = real'(tick_cyc[tick_cyc.size()-1] - tick_cyc[0]) / real'(tick_cyc.size() - 1);
    checks++; if (mean < p - 1.0 || mean > p + 1.0) begin failures++; $display("FAIL %s_period: got %0.3f clk, required %0.3f +-1", name, mean, p); end
    checks++; if (busy_at_fe !== 1'b1 || busy_after !== 1'b0 || idx_after !== 0) begin
      failures++; $display("FAIL %s_busy_fall: busy@fe=%b busy_next=%b idx_next=%0d, required 1 0 0", name, busy_at_fe, busy_after, idx_after);
    end
    $display("frame %s: baud=%0d fe_idx=%0d ticks=%0d delta=%0.0f mean=%0.3f", name, baud_tab[baud], fe_idx, tick_cyc.size(), delta, mean);
  endtask

  // Fastest baud: tick positions must track the ideal line across frames.
  task automatic test_fast_accuracy();
    real p, err, max_e, min_e;
    int  total, obs, expv;
    p = real'(SYS_HZ) / (921600.0 * real'(OS));
    max_e = -1.0e9; min_e = 1.0e9; total = 0;
    for (int fr = 0; fr < 10; fr++) begin
      start_frame(7, 0, 0, 0);
      collect(1000, 0);
      checks++; if (timed_out) begin failures++; $display("FAIL acc_timeout: frame %0d no Frame_End", fr); end
      while (mid_idx.size() > 0) begin
        obs = mid_idx.pop_front();
        checks++;
        if (exp_idx_q.size() == 0) begin failures++; $display("FAIL acc_mid_extra: got Bit_Idx %0d, required none", obs); end
        else begin
          expv = exp_idx_q.pop_front();
          if (obs !== expv) begin failures++; $display("FAIL acc_mid_idx: got %0d, required %0d", obs, expv); end
        end
      end
      checks++; if (exp_idx_q.size() != 0) begin failures++; $display("FAIL acc_mid_missing: %0d left, required 0", exp_idx_q.size()); end
      checks++; if (fe_idx !== 6) begin failures++; $display("FAIL acc_fe_idx: got %0d, required 6", fe_idx); end
      for (int j = 0; j < tick_cyc.size(); j++) begin
        err = real'(tick_cyc[j] - s_cyc) - 1.0 - real'(j + 1) * p;
        if (err > max_e) max_e = err;
        if (err < min_e) min_e = err;
      end
      total += tick_cyc.size();
      $display("frame 5N1@921600 #%0d: ticks=%0d fe_delta=%0d", fr, tick_cyc.size(), fe_cyc - s_cyc);
    end
    checks++; if (total < 1000) begin failures++; $display("FAIL acc_tick_total: got %0d, required >=1000", total); end
    checks++; if (max_e - 0.5 >= 1.0 || 0.5 - min_e >= 1.0) begin
      failures++; $display("FAIL acc_error: err range %0.3f..%0.3f clk, required within 1 clk of ideal", min_e, max_e);
    end
  endtask

  task automatic test_abort();
    int n, act;
    bit found;
    start_frame(4, 3, 0, 0);
    found = 0; n = 0;
    while (!found && n < 6000) begin
      if (sg_if.Bit_Mid && sg_if.Bit_Idx == 4'd3) found = 1;
      else begin @(negedge clk); n++; end
    end
    checks++; if (!found) begin failures++; $display("FAIL abort_reach: Bit_Idx 3 not seen, required"); end
    sg_if.Abort = 1'b1; sg_if.Start = 1'b1;
    @(negedge clk);
    sg_if.Abort = 1'b0; sg_if.Start = 1'b0;
    checks++; if (sg_if.Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b, required 0", sg_if.Busy); end
    checks++; if (sg_if.Bit_Idx !== 4'd0) begin failures++; $display("FAIL abort_idx: got %0d, required 0", sg_if.Bit_Idx); end
    act = 0;
    repeat (600) begin
      @(negedge clk);
      if (sg_if.Busy || sg_if.Sample_Tick || sg_if.Bit_Mid || sg_if.Frame_End) act++;
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL abort_quiet: active cycles %0d, required 0", act); end
    sg_if.Abort = 1'b1; sg_if.Start = 1'b1;
    @(negedge clk);
    sg_if.Abort = 1'b0; sg_if.Start = 1'b0;
    act = 0;
    repeat (100) begin
      if (sg_if.Busy || sg_if.Sample_Tick) act++;
      @(negedge clk);
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL abort_start_idle: active cycles %0d, required 0", act); end
    exp_idx_q.delete();
    $display("abort: frame cancelled at Bit_Idx 3");
  endtask

  // Baseline, disturbed frame, then immediate restart after Frame_End.
  task automatic test_back_to_back();
    int base, delta, obs, expv;
    base = 0;
    for (int f = 0; f < 3; f++) begin
      start_frame(5, 3, 0, 0);
      if (f == 2) begin
        checks++; if (sg_if.Busy !== 1'b1 || sg_if.Bit_Idx !== 4'd0) begin
          failures++; $display("FAIL b2b_restart: busy=%b idx=%0d, required 1 0", sg_if.Busy, sg_if.Bit_Idx);
        end
      end
      collect(3000, f == 1);
      checks++; if (timed_out) begin failures++; $display("FAIL b2b_timeout: frame %0d no Frame_End", f); end
      while (mid_idx.size() > 0) begin
        obs = mid_idx.pop_front();
        checks++;
        if (exp_idx_q.size() == 0) begin failures++; $display("FAIL b2b_mid_extra: got Bit_Idx %0d, required none", obs); end
        else begin
          expv = exp_idx_q.pop_front();
          if (obs !== expv) begin failures++; $display("FAIL b2b_mid_idx: got %0d, required %0d", obs, expv); end
        end
      end
      checks++; if (exp_idx_q.size() != 0) begin failures++; $display("FAIL b2b_mid_missing: %0d left, required 0", exp_idx_q.size()); end
      checks++; if (fe_idx !== 9) begin failures++; $display("FAIL b2b_fe_idx: got %0d, required 9", fe_idx); end
      delta = fe_cyc - s_cyc;
      if (f == 0) base = delta;
      else begin
        checks++; if (delta !== base) begin failures++; $display("FAIL b2b_timing: frame %0d delta %0d, required %0d", f, delta, base); end
      end
      $display("frame b2b #%0d: fe_delta=%0d ticks=%0d", f, delta, tick_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, act, obs, expv;
    bit found;
    start_frame(5, 3, 0, 0);
    found = 0; n = 0;
    while (!found && n < 3000) begin
      if (sg_if.Bit_Idx == 4'd5) found = 1;
      else begin @(negedge clk); n++; end
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_reach: Bit_Idx 5 not seen, required"); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({sg_if.Sample_Tick, sg_if.Bit_Mid, sg_if.Bit_Idx, sg_if.Frame_End, sg_if.Busy} !== 8'h00) begin
      failures++; $display("FAIL rmid_outputs: got tick=%b mid=%b idx=%0d fe=%b busy=%b, required all 0",
                           sg_if.Sample_Tick, sg_if.Bit_Mid, sg_if.Bit_Idx, sg_if.Frame_End, sg_if.Busy);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (300) begin
      @(negedge clk);
      if (sg_if.Busy || sg_if.Sample_Tick || sg_if.Bit_Mid || sg_if.Frame_End) act++;
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL rmid_idle: active cycles %0d, required 0", act); end
    start_frame(5, 3, 0, 0);
    collect(3000, 0);
    checks++; if (timed_out) begin failures++; $display("FAIL rmid_timeout: no Frame_End after restart"); end
    while (mid_idx.size() > 0) begin
      obs = mid_idx.pop_front();
      checks++;
      if (exp_idx_q.size() == 0) begin failures++; $display("FAIL rmid_mid_extra: got Bit_Idx %0d, required none", obs); end
      else begin
        expv = exp_idx_q.pop_front();
        if (obs !== expv) begin failures++; $display("FAIL rmid_mid_idx: got %0d, required %0d", obs, expv); end
      end
    end
    checks++; if (exp_idx_q.size() != 0) begin failures++; $display("FAIL rmid_mid_missing: %0d left, required 0", exp_idx_q.size()); end
    $display("reset mid-frame: recovered, fe_idx=%0d", fe_idx);
  endtask

  initial begin
    test_reset();
    test_frame_timing("c1_9600_8n1", 0, 3, 0, 0, 9, 152);
    test_frame_timing("c2_115200_7e2", 4, 2, 1, 1, 10, 168);
    test_fast_accuracy();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
